// File: rtl/commit_pkg.sv
// Shared types and defaults for the commit stage and its helpers.
package commit_pkg;
  typedef enum logic [1:0] {
    RUN        = 2'd0,
    STORE_WAIT = 2'd1,
    DRAIN      = 2'd2
  } commit_state_t;

  localparam logic [31:0] TRAP_VECTOR_DEFAULT = 32'h0000_0100;
endpackage

// File: rtl/instruction_type_pkg.sv
// Instruction class encodings carried in the ROB commit bundle.
package instruction_type;
  typedef enum logic [1:0] {
    ALU    = 2'd0,
    LOAD   = 2'd1,
    STORE  = 2'd2,
    BRANCH = 2'd3
  } instruction_type_t;
endpackage

// File: rtl/commit_stage_perf_counters.sv
// Retirement statistics; wrap-around counters, present only with COMMIT_PERF_COUNTERS_EN.
module commit_perf_counters (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        commit_i,
  input  logic        mispredict_i,
  input  logic        trap_i,
  output logic [63:0] perf_retired_o,
  output logic [31:0] perf_mispredicts_o,
  output logic [31:0] perf_traps_o
);
  logic [63:0] retired_q;
  logic [31:0] mispredicts_q;
  logic [31:0] traps_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q     <= '0;
      mispredicts_q <= '0;
      traps_q       <= '0;
    end else begin
      if (commit_i)     retired_q     <= retired_q + 64'd1;
      if (mispredict_i) mispredicts_q <= mispredicts_q + 32'd1;
      if (trap_i)       traps_q       <= traps_q + 32'd1;
    end
  end

  assign perf_retired_o     = retired_q;
  assign perf_mispredicts_o = mispredicts_q;
  assign perf_traps_o       = traps_q;
endmodule

// File: rtl/commit_stage.sv
// ROB-head retirement: regfile write, store retire handshake, redirect/flush and drain.
// Optional perf counters are built when COMMIT_PERF_COUNTERS_EN is defined.
//   state      | meaning
//   RUN        | evaluate the ROB head each cycle
//   STORE_WAIT | store presented to the store queue, waiting for acceptance
//   DRAIN      | post-redirect dispatch stall, FLUSH_CYCLES long
module commit_stage
  import commit_pkg::*;
  import instruction_type::*;
#(
  parameter int              XLEN         = 32,
  parameter int              TAG_WIDTH    = 4,
  parameter int              FLUSH_CYCLES = 2,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = TRAP_VECTOR_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [TAG_WIDTH:0]   rob_head,
  input  logic                 rob_commit_valid,
  input  logic [1:0]           rob_commit_instruction_type,
  input  logic                 rob_commit_address_valid,
  input  logic [4:0]           rob_commit_destination,
  input  logic [XLEN-1:0]      rob_commit_value,
  input  logic                 rob_commit_data_ready,
  input  logic                 rob_commit_branch_mispredict,
  input  logic                 rob_commit_exception,
  input  logic [XLEN-1:0]      rob_commit_next_instruction,
  output logic                 commit,
  output logic                 rf_write_en,
  output logic [4:0]           rf_write_addr,
  output logic [XLEN-1:0]      rf_write_data,
  output logic                 stq_commit_valid,
  output logic [TAG_WIDTH:0]   stq_commit_rob_tag,
  input  logic                 stq_commit_ready,
  output logic                 redirect_valid,
  output logic [XLEN-1:0]      redirect_pc,
  output logic                 pipeline_flush,
  output logic                 trap_valid,
  output logic [TAG_WIDTH:0]   trap_rob_tag,
  output logic                 dispatch_stall
`ifdef COMMIT_PERF_COUNTERS_EN
  ,
  output logic [63:0]          perf_retired,
  output logic [31:0]          perf_mispredicts,
  output logic [31:0]          perf_traps
`endif
);
  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  commit_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_store, head_ready, head_trap;

  assign is_store   = (rob_commit_instruction_type == STORE);
  assign head_ready = rob_commit_valid && rob_commit_data_ready &&
                      (!is_store || rob_commit_address_valid);
  assign head_trap  = rob_commit_valid && rob_commit_exception;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (head_trap) begin
          state_d = DRAIN;
          cnt_d   = CNT_W'(FLUSH_CYCLES);
        end else if (head_ready && is_store && !stq_commit_ready) begin
          state_d = STORE_WAIT;
        end else if (head_ready && !is_store && rob_commit_branch_mispredict) begin
          state_d = DRAIN;
          cnt_d   = CNT_W'(FLUSH_CYCLES);
        end
      end
      STORE_WAIT: if (stq_commit_ready) state_d = RUN;
      DRAIN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Outputs are forced low while reset is held so a stale handshake never leaks out.
  always_comb begin
    commit             = 1'b0;
    rf_write_en        = 1'b0;
    rf_write_addr      = '0;
    rf_write_data      = '0;
    stq_commit_valid   = 1'b0;
    stq_commit_rob_tag = '0;
    redirect_valid     = 1'b0;
    redirect_pc        = '0;
    pipeline_flush     = 1'b0;
    trap_valid         = 1'b0;
    trap_rob_tag       = '0;
    dispatch_stall     = 1'b0;
    if (reset) begin
      unique case (state_q)
        RUN: begin
          if (head_trap) begin
            trap_valid     = 1'b1;
            trap_rob_tag   = rob_head;
            redirect_valid = 1'b1;
            redirect_pc    = TRAP_VECTOR;
            pipeline_flush = 1'b1;
          end else if (head_ready && is_store) begin
            stq_commit_valid   = 1'b1;
            stq_commit_rob_tag = rob_head;
            commit             = stq_commit_ready;
          end else if (head_ready) begin
            commit = 1'b1;
            if (rob_commit_destination != 5'd0) begin
              rf_write_en   = 1'b1;
              rf_write_addr = rob_commit_destination;
              rf_write_data = rob_commit_value;
            end
            if (rob_commit_branch_mispredict) begin
              redirect_valid = 1'b1;
              redirect_pc    = rob_commit_next_instruction;
              pipeline_flush = 1'b1;
            end
          end
        end
        // Head cannot advance until this store retires, so rob_head is stable here.
        STORE_WAIT: begin
          stq_commit_valid   = 1'b1;
          stq_commit_rob_tag = rob_head;
          commit             = stq_commit_ready;
        end
        DRAIN:   dispatch_stall = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef COMMIT_PERF_COUNTERS_EN
  commit_perf_counters u_perf (
    .clk                (clk),
    .rst_n              (reset),
    .commit_i           (commit),
    .mispredict_i       (redirect_valid && !trap_valid),
    .trap_i             (trap_valid),
    .perf_retired_o     (perf_retired),
    .perf_mispredicts_o (perf_mispredicts),
    .perf_traps_o       (perf_traps)
  );
`endif
endmodule
